// File: rtl/sha256_ctrl_pkg.sv
// Shared types and constants for the SHA-256 byte-stream controller.
// Optional abort input is enabled by defining SHA_ABORT_EN.
package sha256_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        HSTART,
        HWAIT,
        OUT
    } state_t;

    localparam int          BLOCK_BYTES   = 64;
    localparam int          LEN_FIELD_IDX = 56;
    localparam logic [7:0]  PAD_BYTE      = 8'h80;
    localparam int          DIGEST_BYTES  = 32;

    // Byte of the 64-bit length field for slot 56+lane; lane 0 carries the MSB.
    function automatic logic [7:0] len_byte(input logic [63:0] bit_len, input logic [2:0] lane);
        return bit_len[{~lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sha256_word_packer.sv
// Packs a big-endian byte stream into 32-bit block words; the word write
// fires combinationally on the cycle the fourth byte of a word arrives.
module sha256_word_packer
    import sha256_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic [5:0]  byte_idx,
    output logic [31:0] word,
    output logic        wr_en,
    output logic [3:0]  wr_addr
);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= '0;
                end else if (byte_valid && byte_idx[1:0] == 2'(gi)) begin
                    lane_reg <= byte_data;
                end
            end
        end
    endgenerate

    assign wr_en   = byte_valid && (byte_idx[1:0] == 2'b11);
    assign wr_addr = wr_en ? byte_idx[5:2] : 4'd0;
    assign word    = wr_en ? {g_lane[0].lane_reg, g_lane[1].lane_reg, g_lane[2].lane_reg, byte_data}
                           : 32'd0;

endmodule

// File: rtl/sha256_stream_ctrl.sv
// Byte-stream sequencer for the SHA-256 core: packs, pads, commands blocks
// and streams the digest. Define SHA_ABORT_EN to add the abort input.
module sha256_stream_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter int MSG_LEN_W = 16
) (
    input  logic         clk,
    input  logic         rst,
`ifdef SHA_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         core_wr_en,
    output logic [3:0]   core_wr_addr,
    output logic [31:0]  core_wr_data,
    output logic         core_init,
    output logic         core_next,
    input  logic         core_ready,
    input  logic [255:0] core_digest
);

    state_t                 state_reg;
    logic [5:0]             byte_idx_reg;
    logic [MSG_LEN_W-1:0]   len_reg;
    logic [4:0]             k_reg;
    logic                   first_reg;
    logic                   msg_open_reg;
    logic                   pad_pending_reg;
    logic                   pad80_done_reg;
    logic                   extra_reg;
    logic                   hwait_first_reg;
    logic                   in_ready_reg;
    logic                   out_valid_reg;
    logic [7:0]             out_data_reg;
    logic                   busy_reg;
    logic                   core_init_reg;
    logic                   core_next_reg;

    logic        abort_req;
    logic        accept;
    logic        pad_cycle;
    logic        block_end;
    logic        is_80;
    logic        len_field;
    logic        extra_now;
    logic [63:0] bit_len;
    logic [7:0]  pad_byte;

`ifdef SHA_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    function automatic logic [7:0] digest_byte(input logic [255:0] d, input logic [4:0] k);
        return d[{~k, 3'b000} +: 8];
    endfunction

    assign accept    = in_valid && in_ready_reg;
    assign pad_cycle = (state_reg == PAD);
    assign block_end = (byte_idx_reg == 6'(BLOCK_BYTES - 1));
    assign bit_len   = 64'({len_reg, 3'b000});
    assign is_80     = !pad80_done_reg;
    assign len_field = !is_80 && !extra_reg && (byte_idx_reg >= 6'(LEN_FIELD_IDX));
    // A 0x80 landing in the length slots pushes the length into a fresh block.
    assign extra_now = extra_reg || (is_80 && (byte_idx_reg >= 6'(LEN_FIELD_IDX)));
    assign pad_byte  = is_80 ? PAD_BYTE : (len_field ? len_byte(bit_len, byte_idx_reg[2:0]) : 8'h00);

    sha256_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (accept || pad_cycle),
        .byte_data  (pad_cycle ? pad_byte : in_data),
        .byte_idx   (byte_idx_reg),
        .word       (core_wr_data),
        .wr_en      (core_wr_en),
        .wr_addr    (core_wr_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst || abort_req) begin
            state_reg       <= IDLE;
            byte_idx_reg    <= '0;
            len_reg         <= '0;
            k_reg           <= '0;
            first_reg       <= 1'b1;
            msg_open_reg    <= 1'b0;
            pad_pending_reg <= 1'b0;
            pad80_done_reg  <= 1'b0;
            extra_reg       <= 1'b0;
            hwait_first_reg <= 1'b0;
            in_ready_reg    <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            busy_reg        <= 1'b0;
            core_init_reg   <= 1'b0;
            core_next_reg   <= 1'b0;
        end else begin
            core_init_reg <= 1'b0;
            core_next_reg <= 1'b0;
            case (state_reg)
                IDLE, LOAD: begin
                    if (state_reg == IDLE && !in_ready_reg) begin
                        in_ready_reg <= 1'b1;
                    end else if (accept) begin
                        busy_reg     <= 1'b1;
                        byte_idx_reg <= byte_idx_reg + 6'd1;
                        len_reg      <= len_reg + MSG_LEN_W'(1);
                        msg_open_reg <= !in_last;
                        if (in_last) pad_pending_reg <= 1'b1;
                        if (block_end) begin
                            state_reg     <= HSTART;
                            in_ready_reg  <= 1'b0;
                            core_init_reg <= first_reg;
                            core_next_reg <= !first_reg;
                        end else if (in_last) begin
                            state_reg    <= PAD;
                            in_ready_reg <= 1'b0;
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                end
                PAD: begin
                    byte_idx_reg   <= byte_idx_reg + 6'd1;
                    pad80_done_reg <= 1'b1;
                    if (block_end) begin
                        extra_reg     <= 1'b0;
                        if (!extra_now) pad_pending_reg <= 1'b0;
                        state_reg     <= HSTART;
                        core_init_reg <= first_reg;
                        core_next_reg <= !first_reg;
                    end else begin
                        extra_reg <= extra_now;
                    end
                end
                HSTART: begin
                    first_reg       <= 1'b0;
                    hwait_first_reg <= 1'b1;
                    state_reg       <= HWAIT;
                end
                HWAIT: begin
                    // core_ready may still show the previous idle level for one cycle.
                    if (hwait_first_reg) begin
                        hwait_first_reg <= 1'b0;
                    end else if (core_ready) begin
                        if (msg_open_reg) begin
                            state_reg    <= LOAD;
                            in_ready_reg <= 1'b1;
                        end else if (pad_pending_reg) begin
                            state_reg <= PAD;
                        end else begin
                            state_reg     <= OUT;
                            out_valid_reg <= 1'b1;
                            k_reg         <= '0;
                            out_data_reg  <= digest_byte(core_digest, 5'd0);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (k_reg == 5'(DIGEST_BYTES - 1)) begin
                            state_reg      <= IDLE;
                            out_valid_reg  <= 1'b0;
                            out_data_reg   <= '0;
                            busy_reg       <= 1'b0;
                            len_reg        <= '0;
                            byte_idx_reg   <= '0;
                            k_reg          <= '0;
                            first_reg      <= 1'b1;
                            pad80_done_reg <= 1'b0;
                            extra_reg      <= 1'b0;
                        end else begin
                            k_reg        <= k_reg + 5'd1;
                            out_data_reg <= digest_byte(core_digest, k_reg + 5'd1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;
    assign core_init = core_init_reg;
    assign core_next = core_next_reg;

endmodule
